// File: rtl/mtm_tile_assembler_if.sv
// mtm_tile_assembler_if: row-in / tile-out handshake bundle for the tile assembler
//   slave  : assembler side (takes in_val/in_last/in_row/out_rdy, drives in_rdy/out_val/out_tile/occupancy)
//   master : producer/consumer side, the mirror image
interface mtm_tile_assembler_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_MG = 8,
  parameter int NUM_PE = 8
);
  logic in_val;
  logic in_rdy;
  logic in_last;
  logic [0:NUM_PE-1][DATA_WIDTH-1:0] in_row;
  logic out_val;
  logic out_rdy;
  logic [0:NUM_MG-1][0:NUM_PE-1][DATA_WIDTH-1:0] out_tile;
  logic [1:0] occupancy;
  modport slave (
    input in_val, in_last, in_row, out_rdy,
    output in_rdy, out_val, out_tile, occupancy
  );
  modport master (
    output in_val, in_last, in_row, out_rdy,
    input in_rdy, out_val, out_tile, occupancy
  );
endinterface

// File: rtl/mtm_tile_assembler.sv
// mtm_tile_assembler: packs NUM_PE-wide rows into NUM_MG x NUM_PE tiles via a ping-pong bank pair
//   clk, rst (async, active high)
//   bus.slave : in_val/in_rdy/in_last/in_row row input, out_val/out_rdy/out_tile tile output, occupancy
//   TILE_ASM_PAD_EN : when defined, in_last closes a tile early and zero-fills the remaining rows
module mtm_tile_assembler #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_MG = 8,
  parameter int NUM_PE = 8
) (
  input logic clk,
  input logic rst,
  mtm_tile_assembler_if.slave bus
);
  localparam int RW = NUM_MG > 1 ? $clog2(NUM_MG) : 1;
  localparam logic [RW-1:0] LAST = RW'(NUM_MG - 1);
  logic [0:NUM_MG-1][0:NUM_PE-1][DATA_WIDTH-1:0] bank [2];
  logic [1:0] full;
  logic [1:0] full_n;
  logic [1:0] occ;
  logic wb;
  logic rb;
  logic [RW-1:0] rc;
  logic accept;
  logic fire;
  logic close;
  assign accept = bus.in_val && !full[wb];
  assign fire = full[rb] && bus.out_rdy;
`ifdef TILE_ASM_PAD_EN
  assign close = rc == LAST || bus.in_last;
`else
  logic unused_last;
  assign unused_last = bus.in_last;
  assign close = rc == LAST;
`endif
  // wb and rb never name the same bank when both updates apply: accept needs
  // full[wb] clear, fire needs full[rb] set.
  always_comb begin
    full_n = full;
    if (fire) full_n[rb] = 1'b0;
    if (accept && close) full_n[wb] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank[0] <= '0;
      bank[1] <= '0;
      full <= '0;
      occ <= '0;
      wb <= 1'b0;
      rb <= 1'b0;
      rc <= '0;
    end else begin
      full <= full_n;
      occ <= {1'b0, full_n[0]} + {1'b0, full_n[1]};
      rb <= rb ^ fire;
      if (accept) begin
        bank[wb][rc] <= bus.in_row;
`ifdef TILE_ASM_PAD_EN
        for (int r = 0; r < NUM_MG; r++)
          if (bus.in_last && r > int'(rc)) bank[wb][r] <= '0;
`endif
        wb <= wb ^ close;
        rc <= close ? '0 : rc + 1'b1;
      end
    end
  end
  assign bus.in_rdy = !full[wb];
  assign bus.out_val = full[rb];
  assign bus.out_tile = bank[rb];
  assign bus.occupancy = occ;
endmodule
